// File: rtl/fp_cmp_arbiter_pkg.sv
// rtl/fp_cmp_arbiter_pkg.sv - shared types and widths for the FP compare arbiter
package fp_cmp_arbiter_pkg;

   localparam int FP_W  = 32;
   localparam int CNT_W = 16;

   // IDLE: no result held; RESP: a result is presented on the response port
   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

endpackage

// File: rtl/fp_cmp_arbiter_fp_gt_eq.sv
// rtl/fp_cmp_arbiter_fp_gt_eq.sv - combinational IEEE-754 single bit-rule compare
module fp_gt_eq
   import fp_cmp_arbiter_pkg::*;
(
   input  logic [FP_W-1:0] a,
   input  logic [FP_W-1:0] b,
   output logic            gt,
   output logic            eq
);

   logic mag_gt;

   assign mag_gt = (a[FP_W-2:0] > b[FP_W-2:0]);

   // Sign-magnitude ordering; NaN/denormals just follow the raw bits
   always_comb begin
      eq = (a == b);
      if (a[FP_W-1] != b[FP_W-1]) begin
         gt = ~a[FP_W-1];
      end else if (a == b) begin
         gt = 1'b0;
      end else if (a[FP_W-1]) begin
         gt = ~mag_gt;
      end else begin
         gt = mag_gt;
      end
   end

endmodule

// File: rtl/fp_cmp_arbiter.sv
// rtl/fp_cmp_arbiter.sv - round-robin arbiter sharing one FP comparator
module fp_cmp_arbiter
   import fp_cmp_arbiter_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*FP_W-1:0]     req_a,
   input  logic [NREQ*FP_W-1:0]     req_b,
   output logic [NREQ-1:0]          req_ready,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [$clog2(NREQ)-1:0]  rsp_id,
   output logic                     rsp_gt,
   output logic                     rsp_eq,
   output logic [CNT_W-1:0]         cmp_count
);

   localparam int ID_W = $clog2(NREQ);

   state_t            state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic              rsp_gt_q, rsp_gt_d;
   logic              rsp_eq_q, rsp_eq_d;
   logic [CNT_W-1:0]  cmp_count_q, cmp_count_d;

   logic [FP_W-1:0]   a_arr [NREQ];
   logic [FP_W-1:0]   b_arr [NREQ];
   logic [FP_W-1:0]   a_sel;
   logic [FP_W-1:0]   b_sel;
   logic [ID_W-1:0]   win;
   logic [ID_W-1:0]   cand;
   int                cand_idx;
   logic              found;
   logic              acc;
   logic              cmp_gt;
   logic              cmp_eq;

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign a_arr[i] = req_a[i*FP_W +: FP_W];
      assign b_arr[i] = req_b[i*FP_W +: FP_W];
   end

   // Round-robin search: first valid requester at or after ptr, wrapping
   always_comb begin
      found    = 1'b0;
      win      = '0;
      cand_idx = 0;
      cand     = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand_idx = (int'(ptr_q) + k) % NREQ;
         cand     = ID_W'(cand_idx);
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   // A new compare is taken whenever the output slot is free or draining
   assign acc = rst_n && ((state_q == IDLE) || rsp_ready) && found;

   assign a_sel = a_arr[win];
   assign b_sel = b_arr[win];

   fp_gt_eq u_fp_gt_eq (
      .a  (a_sel),
      .b  (b_sel),
      .gt (cmp_gt),
      .eq (cmp_eq)
   );

   // One-hot accept strobe on the winner, only when the compare is taken
   always_comb begin
      req_ready = '0;
      if (acc) begin
         req_ready[win] = 1'b1;
      end
   end

   // Next-state: load on accept, drain to IDLE when consumed with nothing new
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      rsp_id_d    = rsp_id_q;
      rsp_gt_d    = rsp_gt_q;
      rsp_eq_d    = rsp_eq_q;
      cmp_count_d = cmp_count_q;
      if (acc) begin
         state_d     = RESP;
         ptr_d       = (win == ID_W'(NREQ - 1)) ? '0 : win + 1'b1;
         rsp_id_d    = win;
         rsp_gt_d    = cmp_gt;
         rsp_eq_d    = cmp_eq;
         cmp_count_d = cmp_count_q + CNT_W'(1);
      end else if ((state_q == RESP) && rsp_ready) begin
         state_d = IDLE;
      end
   end

   // State and result registers; reset discards any held result
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         rsp_id_q    <= '0;
         rsp_gt_q    <= 1'b0;
         rsp_eq_q    <= 1'b0;
         cmp_count_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         rsp_id_q    <= rsp_id_d;
         rsp_gt_q    <= rsp_gt_d;
         rsp_eq_q    <= rsp_eq_d;
         cmp_count_q <= cmp_count_d;
      end
   end

   assign rsp_valid = (state_q == RESP);
   assign rsp_id    = rsp_id_q;
   assign rsp_gt    = rsp_gt_q;
   assign rsp_eq    = rsp_eq_q;
   assign cmp_count = cmp_count_q;

endmodule
